dromajo_commit_tx: RTL and testbench

//  Transmit side of the Dromajo cosim commit-trace interface. Takes per-cycle retire slots

---
 rtl/dromajo_commit_tx.sv | 169 ++++++++++++++++
 tb/tb_dromajo_commit_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dromajo_commit_tx.sv
// Commit-trace transmitter for Dromajo cosim: compacts sparse retire slots into a FIFO,
// drains them densely from lane 0 and orders each trap behind the commits accepted with it.
module dromajo_commit_tx #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 16,
  // lanes drained per cycle; lowered only to emulate a slow consumer
  parameter int DRAIN_LANES  = COMMIT_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_xcpt,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic [COMMIT_WIDTH-1:0]      valid,
  output logic [XLEN*COMMIT_WIDTH-1:0] pc,
  output logic [32*COMMIT_WIDTH-1:0]   inst,
  output logic [XLEN*COMMIT_WIDTH-1:0] wdata,
  output logic [XLEN*COMMIT_WIDTH-1:0] mstatus,
  output logic [COMMIT_WIDTH-1:0]      check,
  output logic                         int_xcpt,
  output logic [XLEN-1:0]              cause
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mstatus;
    logic            check;
  } entry_t;

  entry_t                         mem_q [DEPTH];
  entry_t                         mem_d [DEPTH];
  logic [AW-1:0]                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]                count_q, count_d, ahead_q, ahead_d;
  logic                           trap_pending_q, trap_pending_d;
  logic [XLEN-1:0]                trap_cause_q, trap_cause_d;
  logic [COMMIT_WIDTH-1:0]        valid_q, valid_d, check_q, check_d;
  logic [XLEN*COMMIT_WIDTH-1:0]   pc_q, pc_d, wdata_q, wdata_d, mstatus_q, mstatus_d;
  logic [32*COMMIT_WIDTH-1:0]     inst_q, inst_d;
  logic                           int_xcpt_q, int_xcpt_d;
  logic [XLEN-1:0]                cause_q, cause_d;
  logic                           ready;
  logic [CNTW-1:0]                n_pop, n_push;
  entry_t                         e;

  assign ready = !trap_pending_q && (count_q <= CNTW'(DEPTH - COMMIT_WIDTH));

  always_comb begin
    mem_d          = mem_q;
    valid_d        = '0;
    pc_d           = '0;
    inst_d         = '0;
    wdata_d        = '0;
    mstatus_d      = '0;
    check_d        = '0;
    int_xcpt_d     = 1'b0;
    cause_d        = cause_q;
    trap_pending_d = trap_pending_q;
    trap_cause_d   = trap_cause_q;
    ahead_d        = ahead_q;
    e              = '0;

    // pops only see entries present before this cycle, giving the 1-cycle minimum latency
    n_pop = (count_q < CNTW'(DRAIN_LANES)) ? count_q : CNTW'(DRAIN_LANES);
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (CNTW'(l) < n_pop) begin
        e                             = mem_q[rd_ptr_q + AW'(l)];
        valid_d[l]                    = 1'b1;
        pc_d[l*XLEN +: XLEN]          = e.pc;
        inst_d[l*32 +: 32]            = e.inst;
        wdata_d[l*XLEN +: XLEN]       = e.wdata;
        mstatus_d[l*XLEN +: XLEN]     = e.mstatus;
        check_d[l]                    = e.check;
      end
    end
    rd_ptr_d = rd_ptr_q + AW'(n_pop);

    n_push = '0;
    if (ready) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) begin
          mem_d[wr_ptr_q + AW'(n_push)] = '{pc:      in_pc[i*XLEN +: XLEN],
                                            inst:    in_inst[i*32 +: 32],
                                            wdata:   in_wdata[i*XLEN +: XLEN],
                                            mstatus: in_mstatus[i*XLEN +: XLEN],
                                            check:   in_check[i]};
          n_push = n_push + CNTW'(1);
        end
      end
    end
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    count_d  = count_q + n_push - n_pop;

    // ahead counts entries still owed to the cosim before the trap may be reported
    if (trap_pending_q) begin
      if (ahead_q <= n_pop) begin
        int_xcpt_d     = 1'b1;
        cause_d        = trap_cause_q;
        trap_pending_d = 1'b0;
      end else begin
        ahead_d = ahead_q - n_pop;
      end
    end else if (ready && in_xcpt) begin
      trap_pending_d = 1'b1;
      trap_cause_d   = in_cause;
      ahead_d        = count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      ahead_q        <= '0;
      trap_pending_q <= 1'b0;
      trap_cause_q   <= '0;
      valid_q        <= '0;
      pc_q           <= '0;
      inst_q         <= '0;
      wdata_q        <= '0;
      mstatus_q      <= '0;
      check_q        <= '0;
      int_xcpt_q     <= 1'b0;
      cause_q        <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      ahead_q        <= ahead_d;
      trap_pending_q <= trap_pending_d;
      trap_cause_q   <= trap_cause_d;
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      wdata_q        <= wdata_d;
      mstatus_q      <= mstatus_d;
      check_q        <= check_d;
      int_xcpt_q     <= int_xcpt_d;
      cause_q        <= cause_d;
    end
  end

  // storage needs no reset: it is only read below count_q
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign in_ready = ready;
  assign valid    = valid_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign wdata    = wdata_q;
  assign mstatus  = mstatus_q;
  assign check    = check_q;
  assign int_xcpt = int_xcpt_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_dromajo_commit_tx.sv
// Bench for dromajo_commit_tx: a full-rate instance and a 1-lane-drain instance share stimulus;
// a per-instance scoreboard checks every output cycle, plus directed hand-computed checks.
module tb_dromajo_commit_tx;
  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   in_valid;
  logic [127:0] in_pc, in_wdata, in_mstatus;
  logic [63:0]  in_inst;
  logic [1:0]   in_check;
  logic         in_xcpt;
  logic [63:0]  in_cause;

  logic         in_ready_o [2];
  logic [1:0]   valid_o    [2];
  logic [127:0] pc_o       [2];
  logic [63:0]  inst_o     [2];
  logic [127:0] wdata_o    [2];
  logic [127:0] mstatus_o  [2];
  logic [1:0]   check_o    [2];
  logic         int_xcpt_o [2];
  logic [63:0]  cause_o    [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dromajo_commit_tx u_fast (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_check(in_check), .in_xcpt(in_xcpt),
    .in_cause(in_cause), .in_ready(in_ready_o[0]), .valid(valid_o[0]), .pc(pc_o[0]),
    .inst(inst_o[0]), .wdata(wdata_o[0]), .mstatus(mstatus_o[0]), .check(check_o[0]),
    .int_xcpt(int_xcpt_o[0]), .cause(cause_o[0]));

  dromajo_commit_tx #(.DRAIN_LANES(1)) u_slow (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_check(in_check), .in_xcpt(in_xcpt),
    .in_cause(in_cause), .in_ready(in_ready_o[1]), .valid(valid_o[1]), .pc(pc_o[1]),
    .inst(inst_o[1]), .wdata(wdata_o[1]), .mstatus(mstatus_o[1]), .check(check_o[1]),
    .int_xcpt(int_xcpt_o[1]), .cause(cause_o[1]));

  // scoreboard state per instance
  int          lanes [2] = '{2, 1};
  logic [63:0] m_pc [2][256];
  logic [31:0] m_inst [2][256];
  logic [63:0] m_wdata [2][256];
  logic [63:0] m_mstatus [2][256];
  logic        m_check [2][256];
  int          head [2], tail [2], emitted [2], pushed [2], trap_idx [2];
  logic        pend [2];
  logic [63:0] trap_cause [2], cause_hold [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic x, input logic [63:0] cs,
                       input logic [63:0] base);
    logic [63:0] p;
    in_valid = v;
    in_xcpt  = x;
    in_cause = cs;
    for (int i = 0; i < 2; i++) begin
      p                     = base + 64'(4 * i);
      in_pc[i*64 +: 64]     = p;
      in_inst[i*32 +: 32]   = p[31:0] ^ 32'hA5A5_0013;
      in_wdata[i*64 +: 64]  = ~p;
      in_mstatus[i*64 +: 64] = {p[31:0], 32'h0000_1800};
      in_check[i]           = p[2] ^ p[3];
    end
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, 64'h0, 64'hDEAD_0000);
  endtask

  task automatic step();
    logic exp_rdy [2];
    int   n, idx;
    logic exp_x;
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = !pend[d] && ((16 - (tail[d] - head[d])) >= 2);
      if (!reset) check_eq($sformatf("d%0d_in_ready", d), 64'(in_ready_o[d]), 64'(exp_rdy[d]));
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        check_eq($sformatf("d%0d_rst_valid", d), 64'(valid_o[d]), 64'h0);
        check_eq($sformatf("d%0d_rst_pc", d), pc_o[d][63:0] | pc_o[d][127:64], 64'h0);
        check_eq($sformatf("d%0d_rst_xcpt", d), 64'(int_xcpt_o[d]), 64'h0);
        check_eq($sformatf("d%0d_rst_cause", d), cause_o[d], 64'h0);
        head[d] = 0; tail[d] = 0; emitted[d] = 0; pushed[d] = 0;
        pend[d] = 1'b0; cause_hold[d] = 64'h0;
      end else begin
        n = (tail[d] - head[d] < lanes[d]) ? tail[d] - head[d] : lanes[d];
        check_eq($sformatf("d%0d_valid", d), 64'(valid_o[d]), 64'((1 << n) - 1));
        for (int l = 0; l < 2; l++) begin
          idx = (head[d] + l) % 256;
          check_eq($sformatf("d%0d_pc%0d", d, l), pc_o[d][l*64 +: 64], (l < n) ? m_pc[d][idx] : 64'h0);
          check_eq($sformatf("d%0d_inst%0d", d, l), 64'(inst_o[d][l*32 +: 32]),
                   (l < n) ? 64'(m_inst[d][idx]) : 64'h0);
          check_eq($sformatf("d%0d_wdata%0d", d, l), wdata_o[d][l*64 +: 64],
                   (l < n) ? m_wdata[d][idx] : 64'h0);
          check_eq($sformatf("d%0d_mstatus%0d", d, l), mstatus_o[d][l*64 +: 64],
                   (l < n) ? m_mstatus[d][idx] : 64'h0);
          check_eq($sformatf("d%0d_check%0d", d, l), 64'(check_o[d][l]),
                   (l < n) ? 64'(m_check[d][idx]) : 64'h0);
        end
        head[d]    += n;
        emitted[d] += n;
        exp_x = pend[d] && (emitted[d] >= trap_idx[d]);
        if (exp_x) begin
          pend[d]       = 1'b0;
          cause_hold[d] = trap_cause[d];
        end
        check_eq($sformatf("d%0d_int_xcpt", d), 64'(int_xcpt_o[d]), 64'(exp_x));
        check_eq($sformatf("d%0d_cause", d), cause_o[d], cause_hold[d]);
        if (exp_rdy[d]) begin
          for (int i = 0; i < 2; i++) begin
            if (in_valid[i]) begin
              idx = tail[d] % 256;
              m_pc[d][idx]      = in_pc[i*64 +: 64];
              m_inst[d][idx]    = in_inst[i*32 +: 32];
              m_wdata[d][idx]   = in_wdata[i*64 +: 64];
              m_mstatus[d][idx] = in_mstatus[i*64 +: 64];
              m_check[d][idx]   = in_check[i];
              tail[d]++;
              pushed[d]++;
            end
          end
          if (in_xcpt) begin
            pend[d]       = 1'b1;
            trap_idx[d]   = pushed[d];
            trap_cause[d] = in_cause;
          end
        end
        check_eq($sformatf("d%0d_no_overflow", d), 64'(tail[d] - head[d] <= 16), 64'h1);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int first_drop;
    int steps;
    for (int d = 0; d < 2; d++) begin
      head[d] = 0; tail[d] = 0; emitted[d] = 0; pushed[d] = 0; trap_idx[d] = 0;
      pend[d] = 1'b0; trap_cause[d] = 64'h0; cause_hold[d] = 64'h0;
    end
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready_o[0] & in_ready_o[1]), 64'h1);

    // 1: sparse slot 1 compacts into lane 0
    drive(2'b10, 1'b0, 64'h0, 64'h8000_0000);
    step();
    idle();
    step();
    check_eq("t1_valid", 64'(valid_o[0]), 64'h1);
    check_eq("t1_pc0", pc_o[0][63:0], 64'h8000_0004);
    for (int k = 0; k < 4; k++) step();

    // 2: full-rate streaming keeps in_ready high
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 1'b0, 64'h0, 64'h2000 + 64'(8 * k));
      check_eq("t2_ready", 64'(in_ready_o[0]), 64'h1);
      step();
    end
    idle();
    for (int k = 0; k < 12; k++) step();

    // 3: 1-lane drain fills the FIFO; in_ready first drops in push cycle 14
    do_reset();
    first_drop = -1;
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, 1'b0, 64'h0, 64'h3000 + 64'(8 * k));
      if (!in_ready_o[1] && first_drop < 0) first_drop = k;
      step();
    end
    check_eq("t3_first_drop", 64'(first_drop), 64'd14);
    idle();
    for (int k = 0; k < 24; k++) step();

    // 4: trap together with two commits
    do_reset();
    drive(2'b11, 1'b1, 64'h8000_0000_0000_0007, 64'h4000);
    step();
    idle();
    check_eq("t4_ready_low", 64'(in_ready_o[0]), 64'h0);
    step();
    check_eq("t4_valid", 64'(valid_o[0]), 64'h3);
    check_eq("t4_pcA", pc_o[0][63:0], 64'h4000);
    check_eq("t4_pcB", pc_o[0][127:64], 64'h4004);
    check_eq("t4_int_xcpt", 64'(int_xcpt_o[0]), 64'h1);
    check_eq("t4_cause", cause_o[0], 64'h8000_0000_0000_0007);
    check_eq("t4_ready_back", 64'(in_ready_o[0]), 64'h1);
    for (int k = 0; k < 4; k++) step();

    // 5: slow instance holds 5 entries, lone trap fires with the 5th one
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b0, 64'h0, 64'h5000 + 64'(8 * k));
      step();
    end
    drive(2'b00, 1'b1, 64'h5, 64'h0);
    step();
    idle();
    steps = 1;
    while (!int_xcpt_o[1] && steps < 20) begin
      step();
      steps++;
    end
    check_eq("t5_fired", 64'(int_xcpt_o[1]), 64'h1);
    check_eq("t5_fire_cycle", 64'(steps), 64'd5);
    check_eq("t5_last_pc", pc_o[1][63:0], 64'h501C);
    check_eq("t5_cause", cause_o[1], 64'h5);
    for (int k = 0; k < 4; k++) step();

    // 6: reset with 6 entries and a trap pending flushes everything
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 1'b0, 64'h0, 64'h6000 + 64'(8 * k));
      step();
    end
    drive(2'b00, 1'b1, 64'h9, 64'h0);
    step();
    do_reset();
    check_eq("t6_valid", 64'(valid_o[1]), 64'h0);
    check_eq("t6_pc", pc_o[1][63:0], 64'h0);
    check_eq("t6_int_xcpt", 64'(int_xcpt_o[1]), 64'h0);
    check_eq("t6_ready", 64'(in_ready_o[1]), 64'h1);
    for (int k = 0; k < 8; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
